// File: rtl/mp_add_pkg.sv
// Shared definitions for the sequential multi-word adder: FSM encoding and
// the supported operand-length range.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned WORDS_MIN = 2;
  localparam int unsigned WORDS_MAX = 16;

endpackage

// File: rtl/FA_Nbit.sv
// N-bit ripple adder with carry in/out; the only adder in the datapath.
module FA_Nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (N+1)'(cin);

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision adder: streams WORDS operand word pairs
// through one N-bit adder, carrying between words, with ready/valid on both sides.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cin,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             a_word,
  input  logic [N-1:0]             b_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             sum_word,
  output logic [$clog2(WORDS)-1:0] word_idx,
  output logic                     last,
  output logic                     done,
  output logic                     cout_final,
  output logic                     busy
);

  localparam int IW = $clog2(WORDS);
  // One extra count bit so in_cnt can reach WORDS without wrapping
  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  if ((WORDS < WORDS_MIN) || (WORDS > WORDS_MAX)) begin : g_words_range
    $error("mp_add_seq: WORDS out of supported range");
  end

  state_t        state, state_nx;
  logic [CW-1:0] in_cnt;
  logic          carry;
  logic [N-1:0]  fa_sum;
  logic          fa_cout;
  logic          in_hs, out_hs, abort_act, last_in;

  FA_Nbit #(.N(N)) u_fa (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign abort_act = abort && ((state == RUN) || (state == DRAIN));
  assign last_in   = (in_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (abort)                state_nx = IDLE;
        else if (in_hs && last_in) state_nx = DRAIN;
      end
      DRAIN: begin
        if (abort)                state_nx = IDLE;
        else if (out_hs && last)  state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry      <= 1'b0;
      in_cnt     <= '0;
      out_valid  <= 1'b0;
      sum_word   <= '0;
      word_idx   <= '0;
      last       <= 1'b0;
      cout_final <= 1'b0;
    end else if ((state == IDLE) && start) begin
      carry  <= cin;
      in_cnt <= '0;
    end else if (abort_act) begin
      // Abort wins over any handshake in the same cycle
      out_valid <= 1'b0;
      carry     <= 1'b0;
      in_cnt    <= '0;
    end else begin
      if (in_hs) begin
        sum_word  <= fa_sum;
        carry     <= fa_cout;
        word_idx  <= in_cnt[IW-1:0];
        last      <= last_in;
        out_valid <= 1'b1;
        in_cnt    <= in_cnt + 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if ((state == DRAIN) && out_hs && last) cout_final <= carry;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and randomized checks of mp_add_seq at N=8, WORDS=4.
module tb_mp_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a_word = '0;
  logic [N-1:0] b_word = '0;
  logic         in_ready, out_valid, last, done, cout_final, busy;
  logic [N-1:0] sum_word;
  logic [1:0]   word_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cin        (cin),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_word     (a_word),
    .b_word     (b_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_word   (sum_word),
    .word_idx   (word_idx),
    .last       (last),
    .done       (done),
    .cout_final (cout_final),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".in_ready"},   in_ready,   0);
    chk({tag, ".out_valid"},  out_valid,  0);
    chk({tag, ".sum_word"},   sum_word,   0);
    chk({tag, ".word_idx"},   word_idx,   0);
    chk({tag, ".last"},       last,       0);
    chk({tag, ".done"},       done,       0);
    chk({tag, ".cout_final"}, cout_final, 0);
    chk({tag, ".busy"},       busy,       0);
  endtask

  // bp: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  // Called and returns at posedge+1 with the DUT idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int bp, input bit poke_start,
                        output logic [31:0] s, output logic co, output int cyc);
    int sent = 0;
    int recv = 0;
    logic         held_v = 1'b0;
    logic [N-1:0] held_sum = '0;
    logic [1:0]   held_idx = '0;
    s   = '0;
    cyc = 0;
    start = 1'b1;
    cin   = c;
    @(posedge clk); #1;
    start = 1'b0;
    cin   = 1'b0;
    chk("op_busy", busy, 1);
    while (!done && cyc < 100) begin
      case (bp)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start    = poke_start && (cyc == 1);
      cin      = start;
      in_valid = (sent < WORDS);
      a_word   = N'(a >> (N * sent));
      b_word   = N'(b >> (N * sent));
      #1;
      if (held_v && out_valid) begin
        chk("stall_sum", sum_word, held_sum);
        chk("stall_idx", word_idx, held_idx);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("word_idx", word_idx, recv);
        chk("last", last, (recv == WORDS - 1));
        if (recv < WORDS) s[N*recv +: N] = sum_word;
        recv++;
      end
      held_v   = out_valid && !out_ready;
      held_sum = sum_word;
      held_idx = word_idx;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    cin      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("done_seen", done, 1);
    chk("words_recv", recv, WORDS);
    co = cout_final;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_op", busy, 0);
    chk("cout_hold", cout_final, co);
  endtask

  initial begin
    logic [31:0] s;
    logic        co;
    int          cyc;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] ref_sum;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("idle");

    // Single carry ripple into the top word, full throughput
    run_op(32'h00FFFFFF, 32'h00000001, 1'b0, 0, 1'b0, s, co, cyc);
    chk("ripple.sum", s, 32'h01000000);
    chk("ripple.cout", co, 0);
    chk("ripple.cycles", cyc, 5);

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, s, co, cyc);
    chk("wrap.sum", s, 32'h00000000);
    chk("wrap.cout", co, 1);

    run_op(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0, s, co, cyc);
    chk("cin.sum", s, 32'h00000001);
    chk("cin.cout", co, 0);

    // Backpressure pattern 1,0,0,1
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1, 1'b0, s, co, cyc);
    chk("bp.sum", s, 32'hACF13569);
    chk("bp.cout", co, 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1, 1'b0, s, co, cyc);
    chk("bp2.sum", s, 32'h00000001);
    chk("bp2.cout", co, 1);

    // start with cin=1 pulsed mid-operation must be ignored
    run_op(32'h01020304, 32'h10203040, 1'b0, 0, 1'b1, s, co, cyc);
    chk("start_ign.sum", s, 32'h11223344);
    chk("start_ign.cout", co, 0);

    // Abort after two words, abort held over a pending handshake
    start = 1'b1;
    cin   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cin   = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a_word = 8'hFF;
    b_word = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_abort.out_valid", out_valid, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("abort.done_later", done, 0);
    run_op(32'h000000FF, 32'h00000001, 1'b1, 0, 1'b0, s, co, cyc);
    chk("post_abort.sum", s, 32'h00000101);
    chk("post_abort.cout", co, 0);

    // Reset asserted while draining the last word
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a_word = 8'h11;
    b_word = 8'h22;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("drain.busy", busy, 1);
    chk("drain.out_valid", out_valid, 1);
    chk("drain.last", last, 1);
    chk("drain.word_idx", word_idx, 3);
    chk("drain.sum_word", sum_word, 8'h33);
    chk("drain.in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.done", done, 0);
    chk("post_rst.busy", busy, 0);

    // Random operands, carry-in and backpressure against a 33-bit reference
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      run_op(ra, rb, rc, 2, 1'b0, s, co, cyc);
      chk("rand.sum", s, ref_sum[31:0]);
      chk("rand.cout", co, ref_sum[32]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
